// File: rtl/mux_scan_pkg.sv
// Shared state encoding and sizing for the 4:1 mux scan controller.
package mux_scan_pkg;
  localparam int NUM_INPUTS = 4;
  localparam int IDX_W      = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;
endpackage

// File: rtl/mux_scan_controller_settle_timer.sv
// Settle counter: counts 0..SETTLE_CYCLES-1 while enabled, flags terminal count.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [CNT_W-1:0] cnt_q;

  assign tc_o = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  // Wraps to zero at terminal count so it never exceeds SETTLE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tc_o ? '0 : cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/mux_scan_controller.sv
// Sweeps the 4:1 mux select lines, samples its output per index, returns a 4-bit word.
// Define MUX_SCAN_AUTO_RESCAN_EN to restart a sweep immediately after each DONE.
module mux_scan_controller
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);
  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [NUM_INPUTS-2:0]   shadow_q;
  logic [NUM_INPUTS-1:0]   sample_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    tc;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr_i(state_q != SETTLE),
    .en_i (state_q == SETTLE),
    .tc_o (tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      sample_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          idx_q  <= '0;
          done_q <= 1'b0;
          if (start) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        SETTLE: begin
          if (tc) begin
            // Last index bypasses the shadow and lands straight in sample.
            if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
              state_q  <= DONE;
              sample_q <= {mux_out, shadow_q};
              done_q   <= 1'b1;
            end else begin
              shadow_q[idx_q] <= mux_out;
              idx_q           <= idx_q + 1'b1;
            end
          end
        end
        DONE: begin
          done_q <= 1'b0;
          idx_q  <= '0;
`ifdef MUX_SCAN_AUTO_RESCAN_EN
          state_q <= SETTLE;
          busy_q  <= 1'b1;
`else
          state_q <= IDLE;
          busy_q  <= 1'b0;
`endif
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign address0 = idx_q[1];
  assign address1 = idx_q[0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign sample   = sample_q;
endmodule

// File: tb/tb_mux_scan_controller.sv
// Scoreboard bench: two DUTs (SETTLE_CYCLES=2 and 1) each wrapped around a behavioural 4:1 mux.
module tb_mux_scan_controller;
  logic       clk = 1'b0;
  logic       reset;
  logic       start2, start1;
  logic [3:0] in_v;
  logic       a0_2, a1_2, busy2, done2, mo2;
  logic       a0_1, a1_1, busy1, done1, mo1;
  logic [3:0] samp2, samp1;

  always #5 clk = ~clk;

  assign mo2 = in_v[{a0_2, a1_2}];
  assign mo1 = in_v[{a0_1, a1_1}];

  mux_scan_controller #(.SETTLE_CYCLES(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .mux_out(mo2),
    .address0(a0_2), .address1(a1_2), .busy(busy2), .done(done2), .sample(samp2)
  );

  mux_scan_controller #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .mux_out(mo1),
    .address0(a0_1), .address1(a1_1), .busy(busy1), .done(done1), .sample(samp1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] q2[$];
  logic [3:0] q1[$];

  // sel picks which DUT the sweep tasks drive and observe
  logic       sel;
  logic [1:0] cur_a;
  logic       cur_busy, cur_done;
  logic [3:0] cur_sample;
  assign cur_a      = sel ? {a0_1, a1_1} : {a0_2, a1_2};
  assign cur_busy   = sel ? busy1 : busy2;
  assign cur_done   = sel ? done1 : done2;
  assign cur_sample = sel ? samp1 : samp2;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start1 = v;
    else     start2 = v;
  endtask

  // Scoreboard: every done pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && done2) begin
      if (q2.size() == 0) chk("done2_spurious", done2, 0);
      else                chk("sample2", samp2, q2.pop_front());
    end
    if (!reset && done1) begin
      if (q1.size() == 0) chk("done1_spurious", done1, 0);
      else                chk("sample1", samp1, q1.pop_front());
    end
  end

  // Called on a negedge; returns on the negedge two cycles after done.
  task automatic run_sweep(input logic s1, input logic [3:0] pattern, input string nm,
                           input int xa, input int xb);
    int s;
    s   = s1 ? 1 : 2;
    sel = s1;
    in_v = pattern;
    if (s1) q1.push_back(pattern);
    else    q2.push_back(pattern);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    for (int k = 0; k <= 4*s + 1; k++) begin
      if (k < 4*s) chk({nm, "_addr"}, 32'(cur_a), 32'(k / s));
      chk({nm, "_done"}, 32'(cur_done), 32'(k == 4*s));
      chk({nm, "_busy"}, 32'(cur_busy), 32'(k <= 4*s));
      set_start(k == xa || k == xb);
      @(negedge clk);
    end
    set_start(1'b0);
    chk({nm, "_hold"}, 32'(cur_sample), 32'(pattern));
  endtask

  initial begin
    reset  = 1'b1;
    start2 = 1'b0;
    start1 = 1'b0;
    in_v   = 4'b0000;
    sel    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr2", 32'({a0_2, a1_2}), 0);
    chk("rst_busy2", 32'(busy2), 0);
    chk("rst_done2", 32'(done2), 0);
    chk("rst_samp2", 32'(samp2), 0);
    chk("rst_busy1", 32'(busy1), 0);
    chk("rst_samp1", 32'(samp1), 0);
    reset = 1'b0;
    @(negedge clk);

`ifndef MUX_SCAN_AUTO_RESCAN_EN
    // 1: basic sweep, settle 2
    run_sweep(1'b0, 4'b1010, "t1", -1, -1);
    // 2: settle 1
    run_sweep(1'b1, 4'b0110, "t2", -1, -1);

    // 3: reset mid-sweep while index 2 is selected
    sel = 1'b0;
    in_v = 4'b1111;
    q2.push_back(4'b1111);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    repeat (4) @(negedge clk);
    chk("t3_idx2", 32'({a0_2, a1_2}), 2);
    reset = 1'b1;
    q2.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("t3_addr", 32'({a0_2, a1_2}), 0);
    chk("t3_busy", 32'(busy2), 0);
    chk("t3_done", 32'(done2), 0);
    chk("t3_samp", 32'(samp2), 0);
    @(negedge clk);
    run_sweep(1'b0, 4'b0001, "t3b", -1, -1);

    // 4: start pulses during the sweep are ignored
    run_sweep(1'b0, 4'b0111, "t4", 3, 6);
    repeat (3) begin
      chk("t4_idle_busy", 32'(busy2), 0);
      @(negedge clk);
    end

    // 5: start held high across three sweeps, one IDLE cycle between them
    sel = 1'b0;
    in_v = 4'b1100;
    repeat (3) q2.push_back(4'b1100);
    start2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 30; k++) begin
      if (k % 10 < 8 && k < 29) chk("t5_addr", 32'({a0_2, a1_2}), 32'((k % 10) / 2));
      chk("t5_done", 32'(done2), 32'(k == 8 || k == 18 || k == 28));
      chk("t5_busy", 32'(busy2), 32'(k <= 28 && (k % 10) != 9));
      if (k == 28) start2 = 1'b0;
      @(negedge clk);
    end
`else
    // 6: auto-rescan, input changes after sweep 2 has captured indices 0 and 1
    sel = 1'b0;
    in_v = 4'b0011;
    q2.push_back(4'b0011);
    q2.push_back(4'b0111);
    q2.push_back(4'b0101);
    q2.push_back(4'b0101);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int k = 0; k <= 36; k++) begin
      chk("t6_done", 32'(done2), 32'(k == 8 || k == 17 || k == 26 || k == 35));
      chk("t6_busy", 32'(busy2), 1);
      if (k == 13) in_v = 4'b0101;
      @(negedge clk);
    end
    chk("t6_last", 32'(samp2), 32'(4'b0101));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6_stop_busy", 32'(busy2), 0);
`endif

    chk("q2_drained", 32'(q2.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_scan_controller.md
Name: mux_scan_controller

Overview:
Sequential front/back end for the structural 4:1 multiplexer.
- Drives the mux select lines address0/address1 through indices 0..3.
- Holds each index for a programmable settle time, then samples the mux output.
- Assembles the four samples into a 4-bit word and presents it with a one-cycle done pulse and start/busy handshake.
- Sits directly around structuralMultiplexer: upstream of its select inputs, downstream of its out.

Parameters:
- SETTLE_CYCLES, default 2: cycles each index is held before sampling; legal range 1..15.
- CNT_W, default 4: width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: sweep request; honoured only in IDLE.
- mux_out, input, 1: the multiplexer's out.
- address0, output, 1: select MSB, registered.
- address1, output, 1: select LSB, registered.
- busy, output, 1: high from the accepting edge until DONE is left.
- done, output, 1: one-cycle pulse; sample is valid in the same cycle.
- sample, output, 4: bit i = mux_out captured while index i was selected.

Behaviour:
- Index mapping is fixed: index = {address0, address1}. Index 2 means address0=1, address1=0, which selects in2.
- Reset (synchronous): state=IDLE, index=0, cnt=0, address0=address1=0, busy=0, done=0, sample=4'b0000, shadow=0.
- Reset mid-sweep: same values as above. The partial shadow is discarded and sample does not change except being cleared.
- States: IDLE, SETTLE, DONE.
- IDLE: address held at 0, busy=0.
  - start=1 at edge E0 → SETTLE, index=0, cnt=0, busy=1.
- SETTLE, each edge:
  - If cnt==SETTLE_CYCLES-1: shadow[index] <= mux_out, cnt <= 0.
    - index==3 → DONE; sample <= {mux_out, shadow[2:0]}; done <= 1.
    - Otherwise index <= index+1.
  - Else cnt <= cnt+1.
- DONE, lasts exactly one cycle: done=1, busy=1. Next edge → IDLE with done=0, busy=0.
- Timing:
  - Index i is presented for SETTLE_CYCLES cycles.
  - Its capture edge is E0+(i+1)*SETTLE_CYCLES.
  - done is high in the cycle following edge E0+4*SETTLE_CYCLES.
- sample holds its value until the next completed sweep or reset.
- start while busy (SETTLE or DONE) is ignored and not queued.
- start held high continuously: a new sweep begins at the first edge in IDLE.
- SETTLE_CYCLES=1: index advances every edge and captures on every SETTLE edge.
- The counter never exceeds SETTLE_CYCLES-1; there is no wrap beyond it.
- mux_out is treated as synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: MUX_SCAN_AUTO_RESCAN_EN.
- Defined: DONE transitions to SETTLE with index=0, cnt=0 instead of IDLE.
  - busy stays 1 permanently after the first start.
  - done pulses once every 4*SETTLE_CYCLES+1 cycles.
  - Only reset stops scanning.
- Undefined: behaviour exactly as described above (single sweep per start).

Decomposition:
- Package mux_scan_pkg:
  - State encoding constants IDLE=2'd0, SETTLE=2'd1, DONE=2'd2.
  - NUM_INPUTS=4, IDX_W=2.
- One natural sub-module, settle_timer: a CNT_W-bit counter with clear/enable and a terminal-count output at SETTLE_CYCLES-1.
- The FSM, index register and shadow register stay in the top module.

Test Plan:
Bench wires the DUT to a behavioural 4:1 mux: mux_out = in[{address0,address1}].
1. SETTLE_CYCLES=2, in={in3,in2,in1,in0}=4'b1010, pulse start → address sequence 00,00,01,01,10,10,11,11. done high exactly once, 9 cycles after the start edge. sample=4'b1010. busy drops the cycle after done.
2. SETTLE_CYCLES=1, in=4'b0110 → each index held 1 cycle. done 5 cycles after start. sample=4'b0110.
3. Start in=4'b1111, assert reset for one cycle at index 2 → next cycle: all outputs 0, sample=0. A fresh start with in=4'b0001 yields sample=4'b0001.
4. Pulse start again on cycles 3 and 6 of a sweep → ignored; exactly one done pulse. sample matches in at the capture edges.
5. Hold start high across three sweeps, in=4'b1100 → back-to-back sweeps with one IDLE cycle between done and the next acceptance. sample=4'b1100 each time.
6. MUX_SCAN_AUTO_RESCAN_EN defined, SETTLE_CYCLES=2: start once, change in from 4'b0011 to 4'b0101 mid-run → done pulses every 9 cycles. Samples reflect values at each capture edge, ending at 4'b0101. busy stays 1.
